// File: rtl/mem_port_arbiter.sv
// Round-robin access controller sharing one 32x8 bank between
// an instruction-fetch port and a load/store port.
module mem_port_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_f,
    input  logic [AW-1:0] addr_f,
    output logic          ack_f,
    output logic [DW-1:0] rdata_f,
    input  logic          req_d,
    input  logic          we_d,
    input  logic [AW-1:0] addr_d,
    input  logic [DW-1:0] wdata_d,
    output logic          ack_d,
    output logic [DW-1:0] rdata_d,
    output logic          busy,
    output logic          mem_r_w,
    output logic [AW-1:0] mem_addr_out,
    output logic [AW-1:0] mem_addr_in,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // last_grant: 1 = data port, 0 = fetch port
    logic last_grant;
    logic any_req;
    logic grant_d;
    logic start;

    always_comb begin
        any_req = req_f | req_d;
        if (req_f && req_d) begin
            grant_d = ~last_grant;
        end else begin
            grant_d = req_d;
        end
        start = (state == IDLE) && any_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = any_req ? ACCESS : IDLE;
            ACCESS:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        ack_f = (state == DONE) && !last_grant;
        ack_d = (state == DONE) && last_grant;
    end

    // Memory controls only move on the IDLE->ACCESS edge; the write
    // strobe is released on the ACCESS->DONE edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant   <= 1'b1;
            mem_r_w      <= 1'b1;
            mem_addr_out <= '0;
            mem_addr_in  <= '0;
            mem_data_in  <= '0;
            rdata_f      <= '0;
            rdata_d      <= '0;
        end else begin
            if (start) begin
                last_grant   <= grant_d;
                mem_addr_out <= grant_d ? addr_d : addr_f;
                mem_addr_in  <= grant_d ? addr_d : addr_f;
                mem_r_w      <= ~(grant_d & we_d);
                if (grant_d) begin
                    mem_data_in <= wdata_d;
                end
            end
            if (state == ACCESS) begin
                mem_r_w <= 1'b1;
                if (mem_r_w) begin
                    if (last_grant) begin
                        rdata_d <= mem_data_out;
                    end else begin
                        rdata_f <= mem_data_out;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_f;
    logic [AW-1:0] addr_f;
    logic          ack_f;
    logic [DW-1:0] rdata_f;
    logic          req_d;
    logic          we_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic          ack_d;
    logic [DW-1:0] rdata_d;
    logic          busy;
    logic          mem_r_w;
    logic [AW-1:0] mem_addr_out;
    logic [AW-1:0] mem_addr_in;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    logic [DW-1:0] bank [32];
    logic          preload;
    int            rw_falls = 0;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_f        (req_f),
        .addr_f       (addr_f),
        .ack_f        (ack_f),
        .rdata_f      (rdata_f),
        .req_d        (req_d),
        .we_d         (we_d),
        .addr_d       (addr_d),
        .wdata_d      (wdata_d),
        .ack_d        (ack_d),
        .rdata_d      (rdata_d),
        .busy         (busy),
        .mem_r_w      (mem_r_w),
        .mem_addr_out (mem_addr_out),
        .mem_addr_in  (mem_addr_in),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Bank with level-sensitive write strobe and combinational read
    assign mem_data_out = bank[mem_addr_out];

    always @(mem_r_w, mem_addr_in, mem_data_in, preload) begin
        if (preload) begin
            for (int a = 0; a < 32; a++) bank[a] = 8'(31 - a);
        end else if (mem_r_w === 1'b0) begin
            bank[mem_addr_in] = mem_data_in;
        end
    end

    always @(negedge mem_r_w) rw_falls++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ackf"}, ack_f, 0);
        chk({tag, "_ackd"}, ack_d, 0);
        chk({tag, "_rdf"}, rdata_f, 0);
        chk({tag, "_rdd"}, rdata_d, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rw"}, mem_r_w, 1);
        chk({tag, "_aout"}, mem_addr_out, 0);
        chk({tag, "_ain"}, mem_addr_in, 0);
        chk({tag, "_din"}, mem_data_in, 0);
    endtask

    // Reference model state
    logic [DW-1:0] mdl [32];
    int            e, g, free_at, snap, n, both;
    bit            have, last, tport, twe, pf, pd, in_g, in_a;
    logic [AW-1:0] taddr;
    logic [DW-1:0] tdata, tval, exp_rf, exp_rd;
    logic [3:0]    seq;

    initial begin
        reset = 1'b1;
        req_f = 1'b0;
        req_d = 1'b0;
        we_d = 1'b0;
        addr_f = '0;
        addr_d = '0;
        wdata_d = '0;
        preload = 1'b1;
        #1 preload = 1'b0;

        @(negedge clk);
        chk_reset("rst_init");
        reset = 1'b0;
        req_f = 1'b1;
        addr_f = 5'd4;
        @(negedge clk);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk_reset("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        req_f = 1'b0;

        // Fetch read
        req_f = 1'b1;
        addr_f = 5'd3;
        @(negedge clk);
        chk("fr_busy0", busy, 1);
        chk("fr_ack0", ack_f, 0);
        chk("fr_rw0", mem_r_w, 1);
        chk("fr_aout", mem_addr_out, 3);
        @(negedge clk);
        chk("fr_ack1", ack_f, 1);
        chk("fr_ackd", ack_d, 0);
        chk("fr_data", rdata_f, 8'h1C);
        chk("fr_busy1", busy, 1);
        chk("fr_rw1", mem_r_w, 1);
        req_f = 1'b0;
        @(negedge clk);
        chk("fr_ack2", ack_f, 0);
        chk("fr_busy2", busy, 0);
        chk("fr_hold", rdata_f, 8'h1C);

        // Load/store write then read
        req_d = 1'b1;
        we_d = 1'b1;
        addr_d = 5'd5;
        wdata_d = 8'hA5;
        @(negedge clk);
        chk("wr_rw0", mem_r_w, 0);
        chk("wr_ain", mem_addr_in, 5);
        chk("wr_din", mem_data_in, 8'hA5);
        chk("wr_ack0", ack_d, 0);
        @(negedge clk);
        chk("wr_rw1", mem_r_w, 1);
        chk("wr_ack1", ack_d, 1);
        chk("wr_rdd", rdata_d, 0);
        req_d = 1'b0;
        we_d = 1'b0;
        @(negedge clk);
        chk("wr_ack2", ack_d, 0);
        chk("wr_bank", bank[5], 8'hA5);
        req_d = 1'b1;
        @(negedge clk);
        chk("rd_rw0", mem_r_w, 1);
        @(negedge clk);
        chk("rd_ack", ack_d, 1);
        chk("rd_data", rdata_d, 8'hA5);
        req_d = 1'b0;
        @(negedge clk);

        // Contention from reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        addr_f = 5'd1;
        addr_d = 5'd2;
        we_d = 1'b0;
        req_f = 1'b1;
        req_d = 1'b1;
        seq = '0;
        n = 0;
        both = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (ack_f && ack_d) both++;
            if (ack_f) begin
                chk("ct_rdf", rdata_f, 8'd30);
                seq[n] = 1'b0;
                n++;
            end else if (ack_d) begin
                chk("ct_rdd", rdata_d, 8'd29);
                seq[n] = 1'b1;
                n++;
            end
        end
        req_f = 1'b0;
        req_d = 1'b0;
        chk("ct_count", n, 4);
        chk("ct_order", seq, 4'b1010);
        chk("ct_both", both, 0);
        @(negedge clk);
        @(negedge clk);

        // Fetch never writes
        snap = rw_falls;
        we_d = 1'b1;
        wdata_d = 8'h55;
        addr_d = 5'd7;
        addr_f = 5'd7;
        req_f = 1'b1;
        @(negedge clk);
        chk("fw_rw0", mem_r_w, 1);
        @(negedge clk);
        chk("fw_ack", ack_f, 1);
        chk("fw_data", rdata_f, 8'd24);
        req_f = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("fw_falls", rw_falls - snap, 0);
        chk("fw_mem", bank[7], 8'd24);

        // Reset during the ACCESS cycle of a write
        req_d = 1'b1;
        we_d = 1'b1;
        addr_d = 5'd9;
        wdata_d = 8'hFF;
        @(negedge clk);
        chk("rmw_low", mem_r_w, 0);
        reset = 1'b1;
        #1;
        chk("rmw_rw", mem_r_w, 1);
        chk("rmw_busy", busy, 0);
        chk("rmw_ack", ack_d, 0);
        @(negedge clk);
        reset = 1'b0;
        req_d = 1'b0;
        we_d = 1'b0;
        @(negedge clk);
        chk("rmw_ack2", ack_d, 0);
        chk("rmw_idle", busy, 0);
        @(negedge clk);
        chk("rmw_ack3", ack_d, 0);

        // Randomized run against the reference model
        reset = 1'b1;
        preload = 1'b1;
        #1 preload = 1'b0;
        for (int a = 0; a < 32; a++) mdl[a] = 8'(31 - a);
        @(negedge clk);
        reset = 1'b0;
        e = 0;
        g = -10;
        free_at = 0;
        have = 1'b0;
        last = 1'b1;
        pf = 1'b0;
        pd = 1'b0;
        tport = 1'b0;
        twe = 1'b0;
        taddr = '0;
        tdata = '0;
        tval = '0;
        exp_rf = '0;
        exp_rd = '0;
        for (int k = 0; k < 600; k++) begin
            in_g = have && (e == g);
            in_a = have && (e == g + 1);
            if (in_a && !(tport && twe)) begin
                if (tport) exp_rd = tval;
                else exp_rf = tval;
            end
            chk("r_busy", busy, 32'(in_g || in_a));
            chk("r_rw", mem_r_w, 32'(!(in_g && tport && twe)));
            chk("r_ackf", ack_f, 32'(in_a && !tport));
            chk("r_ackd", ack_d, 32'(in_a && tport));
            chk("r_rdf", rdata_f, exp_rf);
            chk("r_rdd", rdata_d, exp_rd);
            if (in_g) begin
                chk("r_aout", mem_addr_out, taddr);
                chk("r_ain", mem_addr_in, taddr);
                if (tport) chk("r_din", mem_data_in, tdata);
            end
            if (in_a) begin
                if (tport) pd = 1'b0;
                else pf = 1'b0;
            end
            if (!pf && ($urandom % 3 == 0)) begin
                pf = 1'b1;
                addr_f = AW'($urandom);
            end
            if (!pd) begin
                we_d = 1'($urandom);
                wdata_d = DW'($urandom);
                addr_d = AW'($urandom);
                if ($urandom % 3 == 0) pd = 1'b1;
            end
            req_f = pf;
            req_d = pd;
            if ((e + 1 >= free_at) && (pf || pd)) begin
                if (pf && pd) tport = !last;
                else tport = pd;
                twe = tport && we_d;
                taddr = tport ? addr_d : addr_f;
                tdata = wdata_d;
                last = tport;
                g = e + 1;
                free_at = g + 3;
                have = 1'b1;
                if (twe) mdl[taddr] = tdata;
                else tval = mdl[taddr];
            end
            @(negedge clk);
            e++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
